oci_trace_capture_buffer: RTL and testbench

//   Parametrised capture FIFO for Nios II OCI debug-trace (DCT) frames in simulation and hardware debug.

---
 rtl/oci_trace_capture_buffer.sv | 106 ++++++++++
 tb/tb_oci_trace_capture_buffer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/oci_trace_capture_buffer.sv
// Capture FIFO for OCI debug-trace frames: stores {dct_count, dct_buffer} while armed,
// drains on test_ending, discards on test_has_ended, and counts frames lost to overflow.
module oci_trace_capture_buffer #(
    parameter int DATA_W = 30,
    parameter int CNT_W  = 4,
    parameter int ADDR_W = 4,
    parameter int DROP_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    arm,
    input  logic                    dct_valid,
    input  logic [DATA_W-1:0]       dct_buffer,
    input  logic [CNT_W-1:0]        dct_count,
    input  logic                    test_ending,
    input  logic                    test_has_ended,
    input  logic                    rd_ready,
    output logic                    rd_valid,
    output logic [CNT_W+DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]         fill_level,
    output logic                    overflow,
    output logic [DROP_W-1:0]       dropped_count,
    output logic                    capture_active,
    output logic                    drain_done
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int FW    = CNT_W + DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_t;

    state_t          state;
    logic [FW-1:0]   mem [DEPTH];
    logic [ADDR_W:0] wr_ptr, rd_ptr;
    logic            full, empty, pop, frame, push, drop, abort;

    assign fill_level = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign rd_valid   = !empty;
    // Gate the head entry so rd_data reads 0 when empty (storage itself is never reset).
    assign rd_data    = rd_valid ? mem[rd_ptr[ADDR_W-1:0]] : '0;
    assign pop        = rd_valid && rd_ready;

    assign abort = test_has_ended && (state == S_CAPTURE || state == S_DRAIN);
    assign frame = (state == S_CAPTURE) && dct_valid && (dct_count != '0) && !test_has_ended;
    // When full, a same-cycle pop frees the slot being written.
    assign push  = frame && (!full || pop);
    assign drop  = frame && full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[ADDR_W-1:0]] <= {dct_count, dct_buffer};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            overflow       <= 1'b0;
            dropped_count  <= '0;
            capture_active <= 1'b0;
            drain_done     <= 1'b0;
        end else begin
            if (abort) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
                if (pop)  rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
            end

            if (drop) begin
                overflow <= 1'b1;
                if (dropped_count != '1) dropped_count <= dropped_count + DROP_W'(1);
            end

            case (state)
                S_IDLE: if (arm) begin
                    state          <= S_CAPTURE;
                    capture_active <= 1'b1;
                end
                S_CAPTURE: if (abort) begin
                    state          <= S_DONE;
                    capture_active <= 1'b0;
                    drain_done     <= 1'b1;
                end else if (test_ending) begin
                    state          <= S_DRAIN;
                    capture_active <= 1'b0;
                end
                S_DRAIN: if (abort || empty || (fill_level == (ADDR_W+1)'(1) && pop)) begin
                    state      <= S_DONE;
                    drain_done <= 1'b1;
                end
                S_DONE: if (arm) begin
                    state          <= S_CAPTURE;
                    capture_active <= 1'b1;
                    drain_done     <= 1'b0;
                    overflow       <= 1'b0;
                    dropped_count  <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_oci_trace_capture_buffer.sv
// Directed bench for oci_trace_capture_buffer: a vector table plus hand-written
// sequences for overflow, drain, abort and reset-mid-drain.
module tb_oci_trace_capture_buffer;
    localparam int DATA_W = 30;
    localparam int CNT_W  = 4;
    localparam int ADDR_W = 4;
    localparam int DROP_W = 3;

    logic                    clk = 1'b0;
    logic                    reset, arm, dct_valid, test_ending, test_has_ended, rd_ready;
    logic [DATA_W-1:0]       dct_buffer;
    logic [CNT_W-1:0]        dct_count;
    logic                    rd_valid, overflow, capture_active, drain_done;
    logic [CNT_W+DATA_W-1:0] rd_data;
    logic [ADDR_W:0]         fill_level;
    logic [DROP_W-1:0]       dropped_count;

    int compared = 0;
    int mismatched = 0;

    oci_trace_capture_buffer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .DROP_W(DROP_W)) dut (
        .clk(clk), .reset(reset), .arm(arm), .dct_valid(dct_valid), .dct_buffer(dct_buffer),
        .dct_count(dct_count), .test_ending(test_ending), .test_has_ended(test_has_ended),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .fill_level(fill_level),
        .overflow(overflow), .dropped_count(dropped_count), .capture_active(capture_active),
        .drain_done(drain_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        arm, vld;
        logic [3:0]  cnt;
        logic [29:0] pay;
        logic        te, the, rdy;
        logic        rv;
        logic [33:0] data;
        logic [4:0]  fill;
        logic        ovf;
        logic [2:0]  drop;
        logic        cap, done;
    } vec_t;

    function automatic vec_t mk(input logic a, v, input logic [3:0] c, input logic [29:0] p,
                                input logic te, th, rd, input logic rv, input logic [33:0] d,
                                input logic [4:0] f, input logic o, input logic [2:0] dr,
                                input logic cp, dn);
        vec_t r;
        r.arm = a; r.vld = v; r.cnt = c; r.pay = p; r.te = te; r.the = th; r.rdy = rd;
        r.rv = rv; r.data = d; r.fill = f; r.ovf = o; r.drop = dr; r.cap = cp; r.done = dn;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic a, v, input logic [3:0] c, input logic [29:0] p,
                        input logic te, th, rd);
        @(negedge clk);
        arm = a; dct_valid = v; dct_count = c; dct_buffer = p;
        test_ending = te; test_has_ended = th; rd_ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push(input logic [3:0] c, input logic [29:0] p);
        step(0, 1, c, p, 0, 0, 0);
    endtask

    function automatic logic [33:0] frm(input int i);
        logic [3:0] c;
        c = 4'((i % 15) + 1);
        return {c, 30'(32'h100 + i)};
    endfunction

    vec_t vt[$];

    initial begin
        int pops;
        reset = 1'b0; arm = 0; dct_valid = 0; dct_count = 0; dct_buffer = 0;
        test_ending = 0; test_has_ended = 0; rd_ready = 0;

        do_reset();
        chk("reset.rd_valid", rd_valid, 0);
        chk("reset.rd_data", rd_data, 0);
        chk("reset.fill", fill_level, 0);
        chk("reset.ovf", overflow, 0);
        chk("reset.drop", dropped_count, 0);
        chk("reset.cap", capture_active, 0);
        chk("reset.done", drain_done, 0);

        //        arm v cnt pay   te th rd  rv data            fill o dr cap done
        vt.push_back(mk(0, 1, 1, 30'h9, 0, 0, 0, 0, 34'h0,            0, 0, 0, 0, 0)); // idle ignores valid
        vt.push_back(mk(1, 0, 0, 30'h0, 0, 0, 0, 0, 34'h0,            0, 0, 0, 1, 0));
        vt.push_back(mk(0, 1, 1, 30'h1, 0, 0, 0, 1, {4'd1, 30'h1},    1, 0, 0, 1, 0));
        vt.push_back(mk(0, 1, 2, 30'h2, 0, 0, 0, 1, {4'd1, 30'h1},    2, 0, 0, 1, 0));
        vt.push_back(mk(0, 1, 3, 30'h3, 0, 0, 0, 1, {4'd1, 30'h1},    3, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 30'h0, 0, 0, 1, 1, {4'd2, 30'h2},    2, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 30'h0, 0, 0, 1, 1, {4'd3, 30'h3},    1, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 30'h0, 0, 0, 1, 0, 34'h0,            0, 0, 0, 1, 0));
        vt.push_back(mk(0, 1, 0, 30'h5, 0, 0, 0, 0, 34'h0,            0, 0, 0, 1, 0)); // zero count
        vt.push_back(mk(0, 1, 4, 30'h44, 1, 0, 0, 1, {4'd4, 30'h44},  1, 0, 0, 0, 0)); // te keeps frame
        vt.push_back(mk(0, 1, 5, 30'h5, 0, 0, 1, 0, 34'h0,            0, 0, 0, 0, 1));
        vt.push_back(mk(0, 1, 1, 30'h1, 0, 1, 0, 0, 34'h0,            0, 0, 0, 0, 1)); // the ignored in DONE
        vt.push_back(mk(1, 0, 0, 30'h0, 0, 0, 0, 0, 34'h0,            0, 0, 0, 1, 0));
        vt.push_back(mk(0, 1, 1, 30'h1, 0, 1, 0, 0, 34'h0,            0, 0, 0, 0, 1)); // abort empty
        vt.push_back(mk(1, 1, 2, 30'h22, 1, 0, 0, 0, 34'h0,           0, 0, 0, 1, 0)); // arm; te ignored
        vt.push_back(mk(1, 1, 2, 30'h22, 0, 0, 0, 1, {4'd2, 30'h22},  1, 0, 0, 1, 0));

        foreach (vt[i]) begin
            step(vt[i].arm, vt[i].vld, vt[i].cnt, vt[i].pay, vt[i].te, vt[i].the, vt[i].rdy);
            chk($sformatf("v%0d.rd_valid", i), rd_valid, vt[i].rv);
            chk($sformatf("v%0d.rd_data", i), rd_data, vt[i].data);
            chk($sformatf("v%0d.fill", i), fill_level, vt[i].fill);
            chk($sformatf("v%0d.ovf", i), overflow, vt[i].ovf);
            chk($sformatf("v%0d.drop", i), dropped_count, vt[i].drop);
            chk($sformatf("v%0d.cap", i), capture_active, vt[i].cap);
            chk($sformatf("v%0d.done", i), drain_done, vt[i].done);
        end

        // Overflow: 18 pushes into 16 entries, then push+pop while full, then saturation.
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++) push(frm(i)[33:30], frm(i)[29:0]);
        chk("ovf.fill", fill_level, 16);
        chk("ovf.flag", overflow, 1);
        chk("ovf.drop", dropped_count, 2);
        chk("ovf.head", rd_data, frm(0));
        step(0, 1, frm(18)[33:30], frm(18)[29:0], 0, 0, 1);
        chk("fullpp.fill", fill_level, 16);
        chk("fullpp.drop", dropped_count, 2);
        chk("fullpp.head", rd_data, frm(1));
        for (int i = 0; i < 6; i++) push(4'd1, 30'h7);
        chk("sat.drop", dropped_count, 7);
        chk("sat.fill", fill_level, 16);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("order%0d", i), rd_data, (i == 16) ? frm(18) : frm(i));
            step(0, 0, 0, 0, 0, 0, 1);
        end
        chk("order.empty", rd_valid, 0);
        chk("order.cap", capture_active, 1);

        // Drain: 5 entries, test_ending with rd_ready, late valids ignored.
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) push(frm(i)[33:30], frm(i)[29:0]);
        chk("drain.fill", fill_level, 5);
        pops = 0;
        for (int k = 0; k < 20 && !drain_done; k++) begin
            @(negedge clk);
            arm = 0; dct_valid = (k > 0); dct_count = 4'd7; dct_buffer = 30'h3ff;
            test_ending = (k == 0); test_has_ended = 0; rd_ready = 1;
            if (rd_valid) begin
                chk($sformatf("drain.pop%0d", pops), rd_data, frm(pops));
                pops++;
            end
            @(posedge clk);
            #1;
        end
        chk("drain.pops", pops, 5);
        chk("drain.done", drain_done, 1);
        chk("drain.fill0", fill_level, 0);
        step(0, 1, 4'd7, 30'h3ff, 0, 0, 0);
        chk("drain.ignore", fill_level, 0);

        // Abort with 7 entries: test_has_ended beats test_ending and dct_valid.
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) push(frm(i)[33:30], frm(i)[29:0]);
        chk("abort.pre", fill_level, 7);
        step(0, 1, 4'd3, 30'h3, 1, 1, 0);
        chk("abort.fill", fill_level, 0);
        chk("abort.rv", rd_valid, 0);
        chk("abort.done", drain_done, 1);
        chk("abort.cap", capture_active, 0);

        // Reset mid-DRAIN, then re-arm.
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) push(frm(i)[33:30], frm(i)[29:0]);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("mid.cap", capture_active, 0);
        chk("mid.fill", fill_level, 3);
        do_reset();
        chk("mid.rst.fill", fill_level, 0);
        chk("mid.rst.rv", rd_valid, 0);
        chk("mid.rst.data", rd_data, 0);
        chk("mid.rst.done", drain_done, 0);
        idle_step();
        chk("mid.idle.cap", capture_active, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        push(4'd9, 30'h2abc);
        chk("rearm.fill", fill_level, 1);
        chk("rearm.data", rd_data, {4'd9, 30'h2abc});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
